// File: rtl/regfile_if.sv
// Register file bus: write-back write port, two decode read ports and the debug read port.
// The master drives requests; the slave (regfile) returns read data and debug acks.
interface regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  logic                  read_enable1;
  logic [ADDR_WIDTH-1:0] read_addr1;
  logic [DATA_WIDTH-1:0] read_result1;
  logic                  read_enable2;
  logic [ADDR_WIDTH-1:0] read_addr2;
  logic [DATA_WIDTH-1:0] read_result2;

  logic                  dbg_req;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic                  dbg_ack;
  logic [DATA_WIDTH-1:0] dbg_data;

  modport master (
    output write_enable, write_addr, write_data,
    output read_enable1, read_addr1, read_enable2, read_addr2,
    output dbg_req, dbg_addr,
    input  read_result1, read_result2, dbg_ack, dbg_data
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  read_enable1, read_addr1, read_enable2, read_addr2,
    input  dbg_req, dbg_addr,
    output read_result1, read_result2, dbg_ack, dbg_data
  );
endinterface

// File: rtl/regfile.sv
// MIPS general-purpose register file: two combinational read ports, one write port, registered debug read.
// Optional macro REGS_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32
) (
  input logic       clock,
  input logic       reset,
  regfile_if.slave  bus
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic                  dbg_ack_q, dbg_ack_d;
  logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
  logic                  wr_en;

  // Writes to register 0 are dropped here, so entry 0 stays at its reset value of 0.
  assign wr_en = bus.write_enable && (bus.write_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.write_addr] <= bus.write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  en,
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    if (!reset && en && (addr != '0)) begin
`ifdef REGS_BYPASS_EN
      if (wr_en && (bus.write_addr == addr)) res = bus.write_data;
      else                                   res = regs_q[addr];
`else
      res = regs_q[addr];
`endif
    end
    return res;
  endfunction

  always_comb begin
    bus.read_result1 = read_port(bus.read_enable1, bus.read_addr1);
    bus.read_result2 = read_port(bus.read_enable2, bus.read_addr2);
  end

  // Debug returns the post-edge value, so a same-edge write is forwarded in both builds.
  always_comb begin
    dbg_ack_d  = bus.dbg_req;
    dbg_data_d = dbg_data_q;
    if (bus.dbg_req) begin
      if (bus.dbg_addr == '0)                         dbg_data_d = '0;
      else if (wr_en && bus.write_addr == bus.dbg_addr) dbg_data_d = bus.write_data;
      else                                            dbg_data_d = regs_q[bus.dbg_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign bus.dbg_ack  = dbg_ack_q;
  assign bus.dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic against an array model.
module tb_regfile;

  logic clock;
  logic reset;

  regfile_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [31:0] model [32];
  logic        exp_ack;
  logic [31:0] exp_dbg;

`ifdef REGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Expected combinational read result given the inputs now on the bus.
  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] addr);
    if (reset || !en || addr == 5'd0) return 32'h0;
    if (BYPASS && bus.write_enable && bus.write_addr != 5'd0 && bus.write_addr == addr)
      return bus.write_data;
    return model[addr];
  endfunction

  // Advance one clock edge, applying the architectural effect of the current inputs to the model.
  task automatic step();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      exp_ack = 1'b0;
      exp_dbg = 32'h0;
    end else begin
      if (bus.write_enable && bus.write_addr != 5'd0) model[bus.write_addr] = bus.write_data;
      exp_ack = bus.dbg_req;
      if (bus.dbg_req) exp_dbg = model[bus.dbg_addr];
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_enable = 1'b0; bus.write_addr = '0; bus.write_data = '0;
    bus.read_enable1 = 1'b0; bus.read_addr1 = '0;
    bus.read_enable2 = 1'b0; bus.read_addr2 = '0;
    bus.dbg_req = 1'b0; bus.dbg_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.dbg_ack !== 1'b0) $display("FAIL reset_dbg_ack: got %b want 0", bus.dbg_ack);
    else passes++;
    checks++;
    if (bus.dbg_data !== 32'h0) $display("FAIL reset_dbg_data: got %h want 0", bus.dbg_data);
    else passes++;
    bus.read_enable1 = 1'b1; bus.read_enable2 = 1'b1;
    for (int a = 1; a < 32; a++) begin
      bus.read_addr1 = a[4:0]; bus.read_addr2 = a[4:0];
      #1;
      checks++;
      if (bus.read_result1 !== 32'h0 || bus.read_result2 !== 32'h0)
        $display("FAIL reset_read a=%0d: got %h/%h want 0", a, bus.read_result1, bus.read_result2);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    bus.write_enable = 1'b1; bus.write_addr = 5'd5; bus.write_data = 32'h1234ABCD;
    step();
    idle_inputs();
    bus.read_enable1 = 1'b1; bus.read_addr1 = 5'd5;
    bus.read_enable2 = 1'b0; bus.read_addr2 = 5'd5;
    #1;
    checks++;
    if (bus.read_result1 !== 32'h1234ABCD) $display("FAIL write_read_p1: got %h want 1234abcd", bus.read_result1);
    else passes++;
    checks++;
    if (bus.read_result2 !== 32'h0) $display("FAIL write_read_p2_disabled: got %h want 0", bus.read_result2);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    bus.write_enable = 1'b1; bus.write_addr = 5'd0; bus.write_data = 32'hFFFFFFFF;
    step();
    idle_inputs();
    bus.read_enable1 = 1'b1; bus.read_enable2 = 1'b1;
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd0;
    #1;
    checks++;
    if (bus.read_result1 !== 32'h0 || bus.read_result2 !== 32'h0)
      $display("FAIL zero_read: got %h/%h want 0", bus.read_result1, bus.read_result2);
    else passes++;
    step();
    checks++;
    if (bus.dbg_ack !== 1'b1 || bus.dbg_data !== 32'h0)
      $display("FAIL zero_dbg: got ack=%b data=%h want ack=1 data=0", bus.dbg_ack, bus.dbg_data);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_bypass();
    bus.write_enable = 1'b1; bus.write_addr = 5'd9; bus.write_data = 32'h00000077;
    bus.read_enable2 = 1'b1; bus.read_addr2 = 5'd9;
    #1;
    checks++;
    if (bus.read_result2 !== (BYPASS ? 32'h77 : 32'h0))
      $display("FAIL bypass_same_cycle: got %h want %h", bus.read_result2, BYPASS ? 32'h77 : 32'h0);
    else passes++;
    step();
    bus.write_enable = 1'b0;
    #1;
    checks++;
    if (bus.read_result2 !== 32'h77) $display("FAIL bypass_next_cycle: got %h want 00000077", bus.read_result2);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs [3] = '{5'd5, 5'd9, 5'd3};
    logic [31:0] want  [3] = '{32'h1234ABCD, 32'h00000077, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      bus.dbg_req = 1'b1; bus.dbg_addr = addrs[i];
      if (i == 2) begin
        bus.write_enable = 1'b1; bus.write_addr = 5'd3; bus.write_data = 32'hCAFEF00D;
      end
      step();
      checks++;
      if (bus.dbg_ack !== 1'b1 || bus.dbg_data !== want[i])
        $display("FAIL dbg_b2b[%0d]: got ack=%b data=%h want ack=1 data=%h", i, bus.dbg_ack, bus.dbg_data, want[i]);
      else passes++;
    end
    idle_inputs();
    step();
    checks++;
    if (bus.dbg_ack !== 1'b0 || bus.dbg_data !== 32'hCAFEF00D)
      $display("FAIL dbg_hold: got ack=%b data=%h want ack=0 data=cafef00d", bus.dbg_ack, bus.dbg_data);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bus.dbg_req = 1'b1; bus.dbg_addr = 5'd5;
    step();
    bus.dbg_req = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.dbg_ack !== 1'b1 || bus.dbg_data !== 32'h1234ABCD)
      $display("FAIL reset_mid_pulse: got ack=%b data=%h want ack=1 data=1234abcd", bus.dbg_ack, bus.dbg_data);
    else passes++;
    bus.dbg_req = 1'b1;
    bus.write_enable = 1'b1; bus.write_addr = 5'd7; bus.write_data = 32'hDEADBEEF;
    step();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (bus.dbg_ack !== 1'b0 || bus.dbg_data !== 32'h0)
      $display("FAIL reset_mid_ack: got ack=%b data=%h want ack=0 data=0", bus.dbg_ack, bus.dbg_data);
    else passes++;
    bus.read_enable1 = 1'b1; bus.read_addr1 = 5'd5;
    bus.read_enable2 = 1'b1; bus.read_addr2 = 5'd7;
    #1;
    checks++;
    if (bus.read_result1 !== 32'h0 || bus.read_result2 !== 32'h0)
      $display("FAIL reset_mid_lost: got %h/%h want 0/0", bus.read_result1, bus.read_result2);
    else passes++;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      reset            = ($urandom_range(0, 59) == 0);
      bus.write_enable = $urandom_range(0, 3) != 0;
      bus.write_addr   = 5'($urandom_range(0, 31));
      bus.write_data   = $urandom;
      bus.read_enable1 = $urandom_range(0, 4) != 0;
      bus.read_addr1   = ($urandom_range(0, 3) == 0) ? bus.write_addr : 5'($urandom_range(0, 31));
      bus.read_enable2 = $urandom_range(0, 4) != 0;
      bus.read_addr2   = ($urandom_range(0, 3) == 0) ? bus.write_addr : 5'($urandom_range(0, 31));
      bus.dbg_req      = $urandom_range(0, 1) != 0;
      bus.dbg_addr     = ($urandom_range(0, 3) == 0) ? bus.write_addr : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_read(bus.read_enable1, bus.read_addr1);
      e2 = exp_read(bus.read_enable2, bus.read_addr2);
      checks++;
      if (bus.read_result1 !== e1 || bus.read_result2 !== e2)
        $display("FAIL rand_read n=%0d: got %h/%h want %h/%h", n, bus.read_result1, bus.read_result2, e1, e2);
      else passes++;
      step();
      checks++;
      if (bus.dbg_ack !== exp_ack || bus.dbg_data !== exp_dbg)
        $display("FAIL rand_dbg n=%0d: got ack=%b data=%h want ack=%b data=%h",
                 n, bus.dbg_ack, bus.dbg_data, exp_ack, exp_dbg);
      else passes++;
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_ack = 1'b0;
    exp_dbg = 32'h0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file of the MIPS CPU; the responder end of the decode stage's register read interface.
- Serves two combinational read ports to decode and one synchronous write port driven by write-back.
- Adds a registered debug read port with a request/acknowledge handshake for the test bench and future debug logic.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register data width (matches REGS_DATA_BUS)
- ADDR_WIDTH, 5, register address width (matches REGS_ADDR_BUS)
- REG_COUNT, 32, number of architectural registers; must equal 2**ADDR_WIDTH

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- write_enable  input  1  write-back write strobe
- write_addr  input  ADDR_WIDTH  write-back destination register
- write_data  input  DATA_WIDTH  write-back data
- read_enable1  input  1  port 1 read request from decode
- read_addr1  input  ADDR_WIDTH  port 1 address
- read_result1  output  DATA_WIDTH  port 1 data, combinational
- read_enable2  input  1  port 2 read request from decode
- read_addr2  input  ADDR_WIDTH  port 2 address
- read_result2  output  DATA_WIDTH  port 2 data, combinational
- dbg_req  input  1  debug read request, sampled on the clock edge
- dbg_addr  input  ADDR_WIDTH  debug read address
- dbg_ack  output  1  debug data valid, registered
- dbg_data  output  DATA_WIDTH  debug read data, registered

Behaviour:
- Storage: REG_COUNT x DATA_WIDTH flops. Entry 0 is never written and always reads 0.
- Reset (synchronous, reset=1 at the edge): all entries cleared to 0; dbg_ack=0; dbg_data=0. A write or debug request presented in the same cycle as reset is dropped.
- Write: at the rising edge with reset=0, write_enable=1 and write_addr!=0, the entry at write_addr takes write_data. A write to address 0 is silently discarded.
- Read ports (each port independent, purely combinational), in priority order:
  - reset=1 -> 0
  - read_enable=0 -> 0
  - addr=0 -> 0
  - same-cycle bypass hit (see Optional Feature) -> write_data
  - otherwise -> stored entry.
- Both read ports may address the same register, and either may match the write address; each port resolves its result independently.
- Debug port, one-cycle latency:
  - At an edge with reset=0 and dbg_req=1: next cycle dbg_ack=1 and dbg_data = the value the entry holds after that edge. This includes a same-edge write to that address; address 0 returns 0.
  - At an edge with dbg_req=0: dbg_ack=0 next cycle and dbg_data holds its last value.
  - Back-to-back requests are legal; an ack is produced every cycle. No backpressure.
- Debug reads never disturb the register contents or the read ports.
- Reset asserted mid-operation: contents are lost and any pending dbg_ack is forced to 0 in the cycle after the reset edge.

Optional Feature:
- Macro: REGS_BYPASS_EN.
- Defined: when write_enable=1, write_addr!=0 and read_addr matches write_addr with the port enabled, that read_result returns write_data in the same cycle (write-to-read forwarding for the write-back/decode hazard).
- Undefined: read ports return the stored value only; the new value is visible from the cycle after the write edge.
- The debug port behaves identically in both builds.

Test Plan:
- Reset, then read both ports at addresses 1..31 with read_enable=1 -> every result is 0x00000000. Check dbg_ack=0 and dbg_data=0 after reset.
- Write 0x1234ABCD to register 5, next cycle read port 1 address 5 with read_enable1=1 and port 2 address 5 with read_enable2=0 -> read_result1=0x1234ABCD, read_result2=0.
- Write 0xFFFFFFFF to register 0, then read address 0 on both ports and via debug -> 0 on all three.
- Same cycle: write 0x00000077 to register 9 and read address 9 on port 2. With REGS_BYPASS_EN: read_result2=0x00000077. Without: old value 0 that cycle, then 0x00000077 the next cycle.
- dbg_req=1 on three consecutive cycles for addresses 5, 9, 3, with register 3 written 0xCAFEF00D on the third edge -> dbg_ack=1 for three cycles, dbg_data = 0x1234ABCD, 0x00000077, 0xCAFEF00D.
- Issue dbg_req for register 5, assert reset on the following edge -> dbg_ack pulses once, then 0. After reset, register 5 reads 0.
